// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell plus sequencing, result assembled LSB-first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start; result and carry held
// SHIFT   | one bit pair per cycle through the adder cell
// DONE    | one-cycle completion pulse, then back to IDLE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_sum, fa_cout, last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  assign fa_sum   = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign fa_cout  = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_SHIFT: begin
        carry_d = fa_cout;
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          state_d = S_DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // On the MSB, carry_q is the carry into the MSB and fa_cout the carry out.
          ovf_d   = carry_q ^ fa_cout;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Outputs are straight flop values or decodes of the state flop only.
  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases and random/exhaustive
// sweeps at WIDTH=8 and WIDTH=4 against an arithmetic reference model.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       cin = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf, ovf4;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .sum(sum), .cout(cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf4),
`endif
    .sum(sum4), .cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed overflow of a+b+cin: operands share a sign that the result does not.
  function automatic logic ovf_model8(input logic [7:0] x, input logic [7:0] y, input logic [7:0] r);
    return (x[7] == y[7]) && (r[7] != x[7]);
  endfunction

  // One full operation on the WIDTH=8 instance, observing every cycle after acceptance.
  // Inputs are scrambled after acceptance to show they were captured.
  task automatic run_op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                         input string tag);
    logic [8:0] e;
    int busy_cnt, done_cnt, done_j;
    e = {1'b0, xa} + {1'b0, xb} + {8'd0, xc};
    busy_cnt = 0; done_cnt = 0; done_j = -1;
    a = xa; b = xb; cin = xc; start = 1'b1;
    tick();
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int j = 1; j <= 12; j++) begin
      if (busy) busy_cnt++;
      if (busy && done) chk({tag, "_busy_and_done"}, 1, 0);
      if (done) begin
        done_cnt++;
        done_j = j;
        chk({tag, "_sum"}, 32'(sum), 32'(e[7:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(ovf_model8(xa, xb, e[7:0])));
`endif
      end
      tick();
    end
    chk({tag, "_done_cycle"}, 32'(done_j), 9);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 8);
    chk({tag, "_done_count"}, 32'(done_cnt), 1);
    chk({tag, "_sum_held"}, 32'(sum), 32'(e[7:0]));
    chk({tag, "_cout_held"}, 32'(cout), 32'(e[8]));
  endtask

  task automatic run_op4(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    logic [4:0] e;
    int waited;
    e = {1'b0, xa} + {1'b0, xb} + {4'd0, xc};
    a4 = xa; b4 = xb; cin4 = xc; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    waited = 0;
    while (!done4 && waited < 10) begin
      tick();
      waited++;
    end
    if (!done4) begin
      chk("w4_done_timeout", 0, 1);
    end else begin
      chk("w4_result", 32'({cout4, sum4}), 32'(e));
`ifdef SERIAL_ADDER_OVF_EN
      chk("w4_ovf", 32'(ovf4), 32'((xa[3] == xb[3]) && (e[3] != xa[3])));
`endif
    end
    tick();
  endtask

  initial begin
    int last_t, npulse;
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_w4", 32'({busy4, done4, cout4, sum4}), 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Directed arithmetic
    run_op8(8'h3C, 8'h0F, 1'b0, "add_3c_0f");
    run_op8(8'hFF, 8'h01, 1'b1, "add_ff_01_c1");
    run_op8(8'h7F, 8'h01, 1'b0, "add_7f_01");
    run_op8(8'h80, 8'h80, 1'b0, "add_80_80");

    // Start re-pulsed during SHIFT (cycle k+3) and DONE (cycle k+9) is ignored
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    begin
      int dcnt, busy_cnt;
      dcnt = 0; busy_cnt = 0;
      for (int j = 1; j <= 14; j++) begin
        start = (j == 3 || j == 9);
        a = 8'hAA; b = 8'hAA; cin = 1'b1;
        if (done) dcnt++;
        if (busy) busy_cnt++;
        tick();
      end
      start = 1'b0;
      chk("repulse_done_count", 32'(dcnt), 1);
      chk("repulse_busy_cycles", 32'(busy_cnt), 8);
      chk("repulse_sum", 32'(sum), 32'h46);
      chk("repulse_cout", 32'(cout), 0);
    end
    run_op8(8'h01, 8'hFE, 1'b1, "after_repulse");

    // Asynchronous reset mid-SHIFT in cycle k+4
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_abort_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_sum", 32'(sum), 0);
    chk("abort_cout", 32'(cout), 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op8(8'h01, 8'h02, 1'b0, "post_reset");

    // Start held high: one acceptance per pass through IDLE
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    last_t = -1; npulse = 0;
    for (int t = 0; t < 45; t++) begin
      if (busy && done) chk("held_busy_and_done", 1, 0);
      if (done) begin
        npulse++;
        chk("held_sum", 32'(sum), 32'h30);
        chk("held_cout", 32'(cout), 0);
        if (last_t >= 0) chk("held_spacing", 32'(t - last_t), 10);
        last_t = t;
      end
      tick();
    end
    start = 1'b0;
    chk("held_pulse_count", 32'(npulse >= 4), 1);
    repeat (12) tick();

    // Random operands at WIDTH=8
    for (int i = 0; i < 25; i++)
      run_op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");

    // Exhaustive sweep at WIDTH=4
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          run_op4(4'(x), 4'(y), 1'(c));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
